// File: rtl/ldpc_enc_frame_ctrl.sv
// Frame sequencer around a wide LDPC encoder core: collects the message as a
// W-bit stream, holds it while the encoder works, captures the codeword and
// streams it back out MSB-first. One frame in flight at a time.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | accepting message words; in_ready=1
//   ENC   | message frozen, waiting ENC_LAT cycles for the encoder
//   DRAIN | codeword captured, emitting output words; out_valid=1
module ldpc_enc_frame_ctrl #(
   parameter int K       = 8193,
   parameter int N       = 9210,
   parameter int W       = 8,
   parameter int ENC_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_last,
   output logic [K-1:0]   enc_msg,
   input  logic [N-1:0]   enc_cw,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy,
   output logic [15:0]    frame_cnt,
   output logic           err_len
);

   localparam int KW    = (K + W - 1) / W;
   localparam int NW    = (N + W - 1) / W;
   // Bits of the final input word that land in the message (1..W).
   localparam int LASTB = K - (KW - 1) * W;
   localparam int IW    = (KW > 1) ? $clog2(KW) : 1;
   localparam int OW    = (NW > 1) ? $clog2(NW) : 1;
   localparam int CW    = (ENC_LAT > 0) ? $clog2(ENC_LAT + 1) : 1;

   localparam logic [IW-1:0] IN_IDX_LAST  = IW'(KW - 1);
   localparam logic [OW-1:0] OUT_IDX_LAST = OW'(NW - 1);
   localparam logic [CW-1:0] WAIT_LAST    = CW'(ENC_LAT);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_ENC   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] in_idx_q, in_idx_d;
   logic [CW-1:0] wait_q, wait_d;
   logic [OW-1:0] out_idx_q, out_idx_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [K-1:0]  msg_q, msg_d;
   logic [N-1:0]  cw_q, cw_d;
   logic          err_len_q, err_len_d;

   // Next-state logic. The message is assembled by shifting words in from the
   // LSB end so that word 0 ends up in the MSBs; the final word contributes
   // only its top LASTB bits. The codeword is likewise shifted out of the MSB
   // end with zero fill, so the padding bits of the last output word are 0.
   always_comb begin
      state_d     = state_q;
      in_idx_d    = in_idx_q;
      wait_d      = wait_q;
      out_idx_d   = out_idx_q;
      frame_cnt_d = frame_cnt_q;
      msg_d       = msg_q;
      cw_d        = cw_q;
      err_len_d   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               if (in_idx_q == IN_IDX_LAST) begin
                  msg_d     = {msg_q[K-LASTB-1:0], in_data[W-1 -: LASTB]};
                  err_len_d = ~in_last;
                  in_idx_d  = '0;
                  wait_d    = '0;
                  state_d   = ST_ENC;
               end else begin
                  msg_d = {msg_q[K-W-1:0], in_data};
                  if (in_last) begin
                     // Short frame: drop it and start over.
                     err_len_d = 1'b1;
                     in_idx_d  = '0;
                  end else begin
                     in_idx_d = in_idx_q + 1'b1;
                  end
               end
            end
         end
         ST_ENC: begin
            if (wait_q == WAIT_LAST) begin
               cw_d      = enc_cw;
               out_idx_d = '0;
               wait_d    = '0;
               state_d   = ST_DRAIN;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               cw_d = {cw_q[N-W-1:0], {W{1'b0}}};
               if (out_idx_q == OUT_IDX_LAST) begin
                  out_idx_d   = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = ST_LOAD;
               end else begin
                  out_idx_d = out_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // State registers with synchronous reset; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_LOAD;
         in_idx_q    <= '0;
         wait_q      <= '0;
         out_idx_q   <= '0;
         frame_cnt_q <= '0;
         msg_q       <= '0;
         cw_q        <= '0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_idx_q    <= in_idx_d;
         wait_q      <= wait_d;
         out_idx_q   <= out_idx_d;
         frame_cnt_q <= frame_cnt_d;
         msg_q       <= msg_d;
         cw_q        <= cw_d;
         err_len_q   <= err_len_d;
      end
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_DRAIN);
   assign out_last  = (state_q == ST_DRAIN) && (out_idx_q == OUT_IDX_LAST);
   assign out_data  = cw_q[N-1 -: W];
   assign enc_msg   = msg_q;
   assign busy      = (state_q != ST_LOAD) || (in_idx_q != '0);
   assign frame_cnt = frame_cnt_q;
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_ldpc_enc_frame_ctrl.sv
// Bench for ldpc_enc_frame_ctrl: stub encoder cw = {msg, all ones} registered,
// a transaction-level reference model, and a per-cycle compare process.
module tb_ldpc_enc_frame_ctrl;

   localparam int K = 8193, N = 9210, W = 8, ENC_LAT = 1;
   localparam int KW = 1025, NW = 1152;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid, out_last, busy, err_len;
   logic [K-1:0]  enc_msg;
   logic [N-1:0]  enc_cw;
   logic [W-1:0]  out_data;
   logic [15:0]   frame_cnt;

   ldpc_enc_frame_ctrl #(.K(K), .N(N), .W(W), .ENC_LAT(ENC_LAT)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .enc_msg(enc_msg),
      .enc_cw(enc_cw), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .frame_cnt(frame_cnt), .err_len(err_len)
   );

   always #5 clk = ~clk;

   // Stub encoder, one cycle of latency.
   always @(posedge clk) enc_cw <= {enc_msg, {(N-K){1'b1}}};

   int checks = 0, failures = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model (frame/transaction level) ----------------
   int          cyc = 0;
   bit          m_loading = 1'b1, m_waiting = 1'b0, m_draining = 1'b0, m_err = 1'b0;
   int          m_nin = 0, m_wait_left = 0, m_nout = 0, m_t_last = 0;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_cur[$];
   logic [7:0]  m_frame[KW];
   logic [K-1:0] m_exp_msg = '0;

   function automatic logic [7:0] exp_word(int i);
      logic [7:0] w;
      int b;
      w = '0;
      for (int j = 0; j < W; j++) begin
         b = i * W + j;
         if (b < K) w[W-1-j] = m_frame[b / W][W-1-(b % W)];
         else if (b < N) w[W-1-j] = 1'b1;
      end
      return w;
   endfunction

   always @(posedge clk) begin : model
      bit e;
      e = 1'b0;
      if (rst) begin
         m_loading = 1'b1; m_waiting = 1'b0; m_draining = 1'b0;
         m_nin = 0; m_nout = 0; m_cnt = '0; m_cur.delete();
      end else begin
         if (m_loading && in_valid) begin
            m_cur.push_back(in_data);
            if (m_nin == KW - 1) begin
               e = !in_last;
               for (int i = 0; i < KW; i++) m_frame[i] = m_cur[i];
               for (int b = 0; b < K; b++) m_exp_msg[K-1-b] = m_frame[b / W][W-1-(b % W)];
               m_cur.delete();
               m_nin = 0; m_loading = 1'b0; m_waiting = 1'b1;
               m_wait_left = 1 + ENC_LAT; m_t_last = cyc;
            end else if (in_last) begin
               e = 1'b1; m_nin = 0; m_cur.delete();
            end else begin
               m_nin++;
            end
         end else if (m_waiting) begin
            m_wait_left--;
            if (m_wait_left == 0) begin
               m_waiting = 1'b0; m_draining = 1'b1; m_nout = 0;
            end
         end else if (m_draining && out_ready) begin
            m_nout++;
            if (m_nout == NW) begin
               m_draining = 1'b0; m_loading = 1'b1; m_cnt++;
            end
         end
      end
      m_err = e;
      cyc++;
   end

   // ---------------- compare process ----------------
   bit         chk_en = 1'b0;
   logic [7:0] obs[NW];
   int         obs_hs = 0, obs_last_n = 0, obs_last_idx = -1, err_n = 0;
   int         first_ov = 0;
   bit         seen_ov = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_loading);
         chk("out_valid", out_valid, m_draining);
         chk("busy", busy, !m_loading || m_nin != 0);
         chk("err_len", err_len, m_err);
         chk("frame_cnt", frame_cnt, m_cnt);
         chk("out_last", out_last, m_draining && m_nout == NW - 1);
         if (m_draining) chk("out_data", out_data, exp_word(m_nout));
         if (m_waiting || m_draining) begin
            checks++;
            if (enc_msg !== m_exp_msg) begin
               failures++;
               $display("FAIL enc_msg actual_low=%0h required_low=%0h",
                        enc_msg[31:0], m_exp_msg[31:0]);
            end
         end
         if (out_valid && out_ready) begin
            if (obs_hs < NW) obs[obs_hs] = out_data;
            if (out_last) begin obs_last_n++; obs_last_idx = obs_hs; end
            obs_hs++;
         end
         if (out_valid && !seen_ov) begin seen_ov = 1'b1; first_ov = cyc; end
         if (err_len) err_n++;
      end
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 0;   // 0: always ready, 1: alternate, 2: random

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = !out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Called aligned to posedge+#1; pat < 0 means random data with idle gaps.
   task automatic send_frame(input int nwords, input int last_at, input int pat);
      for (int i = 0; i < nwords; i++) begin
         while (pat < 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = (pat < 0) ? 8'($urandom) : pat[7:0];
         in_last  = (i == last_at);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 8000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done_in_time"}, in_ready, 1'b1);
   endtask

   task automatic clr_obs();
      obs_hs = 0; obs_last_n = 0; obs_last_idx = -1; seen_ov = 1'b0; err_n = 0;
   endtask

   initial begin
      int n;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_enc_msg_zero", enc_msg == '0, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_cnt", frame_cnt, 16'd0);
      @(posedge clk); #1;

      // Fixed A5 frame, always-ready sink. Word 1024 carries msg bit 0 (=1)
      // followed by seven parity ones -> FF; word 1151 is two ones then pad -> C0.
      rdy_mode = 0; clr_obs();
      send_frame(KW, KW - 1, 'hA5);
      wait_done("s1");
      chk("s1_first_ov_delay", first_ov - m_t_last, 3);
      chk("s1_w0", obs[0], 8'hA5);
      chk("s1_w1023", obs[1023], 8'hA5);
      chk("s1_w1024", obs[1024], 8'hFF);
      chk("s1_w1100", obs[1100], 8'hFF);
      chk("s1_w1151", obs[1151], 8'hC0);
      chk("s1_handshakes", obs_hs, NW);
      chk("s1_last_count", obs_last_n, 1);
      chk("s1_last_idx", obs_last_idx, NW - 1);
      chk("s1_frame_cnt", frame_cnt, 16'd1);
      chk("s1_err_count", err_n, 0);

      // Random data, alternating ready.
      rdy_mode = 1; clr_obs();
      send_frame(KW, KW - 1, -1);
      wait_done("s2");
      chk("s2_handshakes", obs_hs, NW);
      chk("s2_last_count", obs_last_n, 1);
      chk("s2_frame_cnt", frame_cnt, 16'd2);

      // Short frame: in_last on word 10, then a good A5 frame.
      clr_obs();
      send_frame(11, 10, -1);
      repeat (3) begin @(posedge clk); #1; end
      chk("s3_err_count", err_n, 1);
      chk("s3_busy", busy, 1'b0);
      chk("s3_in_ready", in_ready, 1'b1);
      chk("s3_no_output", obs_hs, 0);
      rdy_mode = 0; clr_obs();
      send_frame(KW, KW - 1, 'hA5);
      wait_done("s3b");
      chk("s3b_w1024", obs[1024], 8'hFF);
      chk("s3b_w1151", obs[1151], 8'hC0);
      chk("s3b_frame_cnt", frame_cnt, 16'd3);

      // Missing in_last on the final word: one error pulse, frame still encoded.
      rdy_mode = 2; clr_obs();
      send_frame(KW, -1, -1);
      wait_done("s4");
      chk("s4_err_count", err_n, 1);
      chk("s4_handshakes", obs_hs, NW);
      chk("s4_frame_cnt", frame_cnt, 16'd4);

      // Reset in the middle of draining.
      rdy_mode = 0; clr_obs();
      send_frame(KW, KW - 1, -1);
      n = 0;
      while (obs_hs < 500 && n < 8000) begin @(posedge clk); #1; n++; end
      chk("s5_reached_500", obs_hs >= 500, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("s5_out_valid", out_valid, 1'b0);
      chk("s5_in_ready", in_ready, 1'b1);
      chk("s5_frame_cnt", frame_cnt, 16'd0);
      chk("s5_busy", busy, 1'b0);
      chk("s5_out_data", out_data, 8'h00);
      rdy_mode = 1; clr_obs();
      send_frame(KW, KW - 1, -1);
      wait_done("s5b");
      chk("s5b_handshakes", obs_hs, NW);
      chk("s5b_frame_cnt", frame_cnt, 16'd1);

      // Two more random frames with a random sink.
      rdy_mode = 2;
      for (int f = 0; f < 2; f++) begin
         clr_obs();
         send_frame(KW, KW - 1, -1);
         wait_done("s6");
         chk("s6_handshakes", obs_hs, NW);
         chk("s6_last_count", obs_last_n, 1);
      end
      chk("s6_frame_cnt", frame_cnt, 16'd3);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
